// File: rtl/pc_pipe_reg.sv
// PC pipeline register with valid/ready handshake and a saturating stall counter.
// Define PC_PIPE_REG_SKID_EN for a two-entry skid buffer with a registered ready.
module pc_pipe_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(32'h0000_0000),
  parameter int unsigned      CNT_W     = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             in_valid_in,
  input  logic [WIDTH-1:0] in_data_in,
  output logic             in_ready_out,
  output logic             out_valid_out,
  output logic [WIDTH-1:0] out_data_out,
  input  logic             out_ready_in,
  output logic [CNT_W-1:0] stall_cnt_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             main_v_q, main_v_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_c;
  logic             in_fire_c;
  logic             out_fire_c;

`ifdef PC_PIPE_REG_SKID_EN
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  // Ready comes only from the skid flop; rst_in masks it while reset is held.
  assign ready_c = rst_in & ~skid_v_q;
`else
  logic             skid_v_q;
  assign skid_v_q = 1'b0;
  assign ready_c  = rst_in & (~main_v_q | out_ready_in);
`endif

  assign in_fire_c  = in_valid_in & ready_c;
  assign out_fire_c = main_v_q & out_ready_in;

  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    cnt_d       = cnt_q;
`ifdef PC_PIPE_REG_SKID_EN
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
`endif

    if (!flush_in && main_v_q && !out_ready_in && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (flush_in) begin
      main_v_d = 1'b0;
`ifdef PC_PIPE_REG_SKID_EN
      skid_v_d = 1'b0;
`endif
    end else if (out_fire_c || !main_v_q) begin
      // Main entry is free this edge: refill from skid first to keep order.
      if (skid_v_q) begin
`ifdef PC_PIPE_REG_SKID_EN
        main_v_d    = 1'b1;
        main_data_d = skid_data_q;
        skid_v_d    = 1'b0;
`endif
      end else if (in_fire_c) begin
        main_v_d    = 1'b1;
        main_data_d = in_data_in;
      end else begin
        main_v_d    = 1'b0;
      end
    end else if (in_fire_c) begin
`ifdef PC_PIPE_REG_SKID_EN
      skid_v_d    = 1'b1;
      skid_data_d = in_data_in;
`endif
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      main_v_q    <= 1'b0;
      main_data_q <= RESET_VAL;
      cnt_q       <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef PC_PIPE_REG_SKID_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
    end else begin
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
    end
  end
`endif

  assign in_ready_out  = ready_c;
  assign out_valid_out = main_v_q;
  assign out_data_out  = main_data_q;
  assign stall_cnt_out = cnt_q;

endmodule

// File: tb/tb_pc_pipe_reg.sv
// Directed bench for pc_pipe_reg: vector table plus stall, flush, ordering and reset sequences.
module tb_pc_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n, flush, iv, ordy;
  logic [31:0] id;
  logic        rdy, ov;
  logic [31:0] od;
  logic [7:0]  st;
  logic        s_rdy, s_ov;
  logic [31:0] s_od;
  logic [1:0]  s_st;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_pipe_reg #(.WIDTH(32), .RESET_VAL(32'h0000_1000), .CNT_W(8)) dut (
    .clk_in(clk), .rst_in(rst_n), .flush_in(flush), .in_valid_in(iv), .in_data_in(id),
    .in_ready_out(rdy), .out_valid_out(ov), .out_data_out(od), .out_ready_in(ordy),
    .stall_cnt_out(st));

  pc_pipe_reg #(.WIDTH(32), .RESET_VAL(32'h0000_1000), .CNT_W(2)) dut_sat (
    .clk_in(clk), .rst_in(rst_n), .flush_in(flush), .in_valid_in(iv), .in_data_in(id),
    .in_ready_out(s_rdy), .out_valid_out(s_ov), .out_data_out(s_od), .out_ready_in(ordy),
    .stall_cnt_out(s_st));

  typedef struct {
    logic        flush;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic [7:0]  e_st;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic f, input logic v, input logic [31:0] d, input logic r);
    @(negedge clk);
    flush = f; iv = v; id = d; ordy = r;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  logic skid;
  logic r0, rdy_s, ov_s, ordy_t;
  logic [31:0] od_s;
  int sent, got;

  initial begin
`ifdef PC_PIPE_REG_SKID_EN
    skid = 1'b1;
`else
    skid = 1'b0;
`endif
    rst_n = 1'b0; flush = 1'b0; iv = 1'b0; id = '0; ordy = 1'b0;

    // Streaming, idle retention, and loading the stall beat.
    vecs[0] = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0,   8'd0};
    vecs[1] = '{1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 32'h4,   8'd0};
    vecs[2] = '{1'b0, 1'b1, 32'h8, 1'b1, 1'b1, 1'b1, 32'h8,   8'd0};
    vecs[3] = '{1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 32'hC,   8'd0};
    vecs[4] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'hC,   8'd0};
    vecs[5] = '{1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h100, 8'd0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", 64'(ov), 64'(0));
    chk("rst_od", 64'(od), 64'h1000);
    chk("rst_st", 64'(st), 64'(0));
    chk("rst_rdy", 64'(rdy), 64'(0));

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].flush, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      chk($sformatf("vec%0d_rdy", i), 64'(rdy), 64'(vecs[i].e_rdy));
      edge_wait();
      chk($sformatf("vec%0d_ov", i), 64'(ov), 64'(vecs[i].e_ov));
      chk($sformatf("vec%0d_od", i), 64'(od), 64'(vecs[i].e_od));
      chk($sformatf("vec%0d_st", i), 64'(st), 64'(vecs[i].e_st));
    end

    // Stall 0x100 for 5 cycles while 0x104 is offered.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 32'h104, 1'b0);
      chk($sformatf("stall%0d_rdy", i), 64'(rdy), 64'(skid && (i == 0)));
      edge_wait();
      chk($sformatf("stall%0d_ov", i), 64'(ov), 64'(1));
      chk($sformatf("stall%0d_od", i), 64'(od), 64'h100);
      chk($sformatf("stall%0d_st", i), 64'(st), 64'(i + 1));
      chk($sformatf("stall%0d_sat", i), 64'(s_st), 64'((i + 1 > 3) ? 3 : i + 1));
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    edge_wait();
    chk("sat6_st", 64'(st), 64'(6));
    chk("sat6_sat", 64'(s_st), 64'(3));

    // Release the stall.
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rel0_rdy", 64'(rdy), 64'(!skid));
    edge_wait();
    chk("rel0_ov", 64'(ov), 64'(skid));
    chk("rel0_od", 64'(od), skid ? 64'h104 : 64'h100);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rel1_rdy", 64'(rdy), 64'(1));
    edge_wait();
    chk("rel1_ov", 64'(ov), 64'(0));
    chk("rel1_od", 64'(od), skid ? 64'h104 : 64'h100);
    chk("rel1_st", 64'(st), 64'(6));

    // Flush with 0x200 held, 0x204 offered, then 0x208 presented at the flush edge.
    drive(1'b0, 1'b1, 32'h200, 1'b0);
    edge_wait();
    chk("fl_load_od", 64'(od), 64'h200);
    drive(1'b0, 1'b1, 32'h204, 1'b0);
    chk("fl_204_rdy", 64'(rdy), 64'(skid));
    edge_wait();
    chk("fl_204_st", 64'(st), 64'(7));
    drive(1'b1, 1'b1, 32'h208, 1'b0);
    edge_wait();
    chk("fl_ov", 64'(ov), 64'(0));
    chk("fl_od", 64'(od), 64'h200);
    chk("fl_st", 64'(st), 64'(7));
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      edge_wait();
      chk($sformatf("fl_idle%0d_ov", i), 64'(ov), 64'(0));
    end

    // Ordering with out_ready toggling; scoreboard expects 0x0..0x3C in sequence.
    sent = 0; got = 0; ordy_t = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
      drive(1'b0, sent < 16, 32'(sent * 4), ordy_t);
`ifdef PC_PIPE_REG_SKID_EN
      r0 = rdy;
      ordy = ~ordy_t;
      #1;
      chk("rdy_indep", 64'(rdy), 64'(r0));
      ordy = ordy_t;
      #1;
`endif
      rdy_s = rdy; ov_s = ov; od_s = od;
      @(posedge clk);
      if (ov_s && ordy_t) begin
        chk($sformatf("order%0d", got), 64'(od_s), 64'(got * 4));
        got++;
      end
      if (iv && rdy_s) sent++;
      ordy_t = ~ordy_t;
    end
    chk("delivered", 64'(got), 64'(16));
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    edge_wait();
    chk("order_tail_ov", 64'(ov), 64'(0));

    // Reset asserted mid-stall, mid-cycle.
    drive(1'b0, 1'b1, 32'h300, 1'b0);
    edge_wait();
    drive(1'b0, 1'b1, 32'h304, 1'b0);
    edge_wait();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov", 64'(ov), 64'(0));
    chk("arst_od", 64'(od), 64'h1000);
    chk("arst_st", 64'(st), 64'(0));
    chk("arst_sat", 64'(s_st), 64'(0));
    chk("arst_rdy", 64'(rdy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    iv = 1'b0; ordy = 1'b1;
    edge_wait();
    chk("post_rst_ov", 64'(ov), 64'(0));
    drive(1'b0, 1'b1, 32'h400, 1'b1);
    chk("post_rst_rdy", 64'(rdy), 64'(1));
    edge_wait();
    chk("post_rst_od", 64'(od), 64'h400);
    chk("post_rst_v", 64'(ov), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
